// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared types and helpers for the byte-addressed data memory
package data_mem_pkg;

  // RV32 load/store funct3 encodings understood by the memory
  typedef enum logic [2:0] {
    W_B  = 3'b000,
    W_H  = 3'b001,
    W_W  = 3'b010,
    W_BU = 3'b100,
    W_HU = 3'b101
  } mem_width_e;

  // CLEAR sweeps the array to zero after reset, IDLE serves requests
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } dmem_state_e;

  // Natural alignment check; illegal widths report aligned and are caught separately
  function automatic logic is_aligned(input logic [2:0] width, input logic [1:0] addr_lo);
    case (width)
      W_H, W_HU: is_aligned = ~addr_lo[0];
      W_W:       is_aligned = (addr_lo == 2'b00);
      default:   is_aligned = 1'b1;
    endcase
  endfunction

  // Unsigned widths exist only for loads; reserved encodings never legal
  function automatic logic is_legal_width(input logic [2:0] width, input logic is_store);
    case (width)
      W_B, W_H, W_W: is_legal_width = 1'b1;
      W_BU, W_HU:    is_legal_width = ~is_store;
      default:       is_legal_width = 1'b0;
    endcase
  endfunction

  // Expand a 4-bit byte mask into a 32-bit bit mask
  function automatic logic [31:0] expand_mask(input logic [3:0] byte_mask);
    expand_mask = {{8{byte_mask[3]}}, {8{byte_mask[2]}}, {8{byte_mask[1]}}, {8{byte_mask[0]}}};
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane mask, store replication and load extension for one access
module mem_lane_align
  import data_mem_pkg::*;
(
  input  logic [2:0]  width,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] write_data,
  input  logic [31:0] raw_word,
  output logic [3:0]  byte_mask,
  output logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Pick the addressed byte and half-word out of the raw memory word
  always_comb begin
    lane_byte = raw_word[7:0];
    case (addr_lo)
      2'b00: lane_byte = raw_word[7:0];
      2'b01: lane_byte = raw_word[15:8];
      2'b10: lane_byte = raw_word[23:16];
      2'b11: lane_byte = raw_word[31:24];
      default: lane_byte = raw_word[7:0];
    endcase
    lane_half = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];
  end

  // Store data is replicated across lanes so the mask alone selects the target bytes
  always_comb begin
    byte_mask  = 4'b0000;
    store_data = write_data;
    case (width)
      W_B, W_BU: begin
        byte_mask  = 4'b0001 << addr_lo;
        store_data = {4{write_data[7:0]}};
      end
      W_H, W_HU: begin
        byte_mask  = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_data = {2{write_data[15:0]}};
      end
      W_W: begin
        byte_mask  = 4'b1111;
        store_data = write_data;
      end
      default: begin
        byte_mask  = 4'b0000;
        store_data = write_data;
      end
    endcase
  end

  // Sign- or zero-extend the selected lane into a full register value
  always_comb begin
    load_data = 32'h0000_0000;
    case (width)
      W_B:     load_data = {{24{lane_byte[7]}}, lane_byte};
      W_BU:    load_data = {24'h000000, lane_byte};
      W_H:     load_data = {{16{lane_half[15]}}, lane_half};
      W_HU:    load_data = {16'h0000, lane_half};
      W_W:     load_data = raw_word;
      default: load_data = 32'h0000_0000;
    endcase
  end

  assign misaligned = ~is_aligned(width, addr_lo);

endmodule

// File: rtl/byte_data_memory.sv
// rtl/byte_data_memory.sv - byte-addressed RV32 data memory; BYTE_DATA_MEMORY_BOUNDS_CHECK_EN faults out-of-range addresses
module byte_data_memory
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        width,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       write_data,
  output logic              resp_valid,
  output logic [31:0]       read_data,
  output logic              fault
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

  logic [31:0]      mem [DEPTH_WORDS];
  dmem_state_e      state;
  logic [IDX_W-1:0] clr_idx;

  logic [IDX_W-1:0] word_idx;
  logic [1:0]       addr_lo;
  logic [31:0]      raw_word;
  logic [3:0]       byte_mask;
  logic [31:0]      store_data;
  logic [31:0]      load_data;
  logic             misaligned;
  logic             out_of_range;
  logic             req_fault;
  logic             accept;
  logic             do_store;
  logic [31:0]      merged_word;

  assign word_idx = address[IDX_W+1:2];
  assign addr_lo  = address[1:0];
  assign raw_word = mem[word_idx];

`ifdef BYTE_DATA_MEMORY_BOUNDS_CHECK_EN
  assign out_of_range = |address[ADDR_W-1:IDX_W+2];
`else
  // Upper bits are deliberately ignored so accesses wrap around the array
  logic unused_upper_addr;
  assign unused_upper_addr = ^address[ADDR_W-1:IDX_W+2];
  assign out_of_range      = 1'b0;
`endif

  mem_lane_align u_lane_align (
    .width      (width),
    .addr_lo    (addr_lo),
    .write_data (write_data),
    .raw_word   (raw_word),
    .byte_mask  (byte_mask),
    .store_data (store_data),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;

  // A request is rejected for direction ambiguity, bad width, misalignment or range
  assign req_fault = (mem_read == mem_write)
                   | ~is_legal_width(width, mem_write)
                   | misaligned
                   | out_of_range;

  assign do_store    = accept & mem_write & ~req_fault;
  assign merged_word = (raw_word & ~expand_mask(byte_mask)) | (store_data & expand_mask(byte_mask));

  // Clear sweep runs from index 0 to the last word, then the array is open for requests
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else if (state == CLEAR) begin
      clr_idx <= clr_idx + 1'b1;
      if (clr_idx == LAST_IDX) begin
        state <= IDLE;
      end
    end
  end

  // Array writes: zeroing during the sweep, masked merge for accepted stores
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_idx] <= 32'h0000_0000;
    end else if (do_store) begin
      mem[word_idx] <= merged_word;
    end
  end

  // Registered response; data and fault hold between pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid <= 1'b0;
      fault      <= 1'b0;
      read_data  <= 32'h0000_0000;
    end else begin
      resp_valid <= accept;
      if (accept) begin
        fault     <= req_fault;
        read_data <= (req_fault || !mem_read) ? 32'h0000_0000 : load_data;
      end
    end
  end

endmodule

// File: tb/tb_byte_data_memory.sv
// tb/tb_byte_data_memory.sv - scoreboard bench for byte_data_memory
module tb_byte_data_memory;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  width;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        resp_valid;
  logic [31:0] read_data;
  logic        fault;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        flt;
    int          at;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  byte_data_memory #(.DEPTH_WORDS(DEPTH), .ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .width      (width),
    .address    (address),
    .write_data (write_data),
    .resp_valid (resp_valid),
    .read_data  (read_data),
    .fault      (fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp_valid=1 with data %h expected no pending request", read_data);
      end else begin
        mon_e = q.pop_front();
        check({mon_e.name, "_data"}, read_data, mon_e.data);
        check({mon_e.name, "_fault"}, {31'd0, fault}, {31'd0, mon_e.flt});
        check({mon_e.name, "_latency"}, cyc, mon_e.at);
      end
    end
  end

  task automatic req(input string nm, input logic rd, input logic wr, input logic [2:0] w,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] ed, input logic ef);
    exp_t e;
    req_valid  = 1'b1;
    mem_read   = rd;
    mem_write  = wr;
    width      = w;
    address    = a;
    write_data = wd;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready: got req_ready=%b expected 1", nm, req_ready);
    end else begin
      e.name = nm;
      e.data = ed;
      e.flt  = ef;
      e.at   = cyc + 1;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (req_ready !== 1'b1 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic drain(input string nm);
    repeat (3) @(posedge clk);
    #1;
    check({nm, "_drained"}, q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset      = 1'b1;
    req_valid  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    width      = 3'b000;
    address    = 32'h0;
    write_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_read_data", read_data, 32'h0);

    // Test 1: request held during the sweep is not accepted
    req_valid = 1'b1;
    mem_read  = 1'b1;
    width     = 3'b010;
    address   = 32'h10;
    reset     = 1'b0;
    wait_ready(n);
    check("clear_sweep_len", n, DEPTH);
    req_valid = 1'b0;
    req("t1_lw10", 1, 0, 3'b010, 32'h10, 32'h0, 32'h0000_0000, 0);

    // Test 2: sub-word loads of a stored word
    req("t2_sw20", 0, 1, 3'b010, 32'h20, 32'hDEADBEEF, 32'h0, 0);
    req("t2_lb23", 1, 0, 3'b000, 32'h23, 32'h0, 32'hFFFFFFDE, 0);
    req("t2_lbu23", 1, 0, 3'b100, 32'h23, 32'h0, 32'h000000DE, 0);
    req("t2_lh22", 1, 0, 3'b001, 32'h22, 32'h0, 32'hFFFFDEAD, 0);
    req("t2_lhu20", 1, 0, 3'b101, 32'h20, 32'h0, 32'h0000BEEF, 0);

    // Test 3: byte-lane stores preserve the other lanes
    req("t3_sw40", 0, 1, 3'b010, 32'h40, 32'h11223344, 32'h0, 0);
    req("t3_sb41", 0, 1, 3'b000, 32'h41, 32'h000000AA, 32'h0, 0);
    req("t3_sh42", 0, 1, 3'b001, 32'h42, 32'h00005566, 32'h0, 0);
    req("t3_lw40", 1, 0, 3'b010, 32'h40, 32'h0, 32'h5566AA44, 0);

    // Test 4: faults leave memory untouched
    req("t4_lw06", 1, 0, 3'b010, 32'h06, 32'h0, 32'h0, 1);
    req("t4_sh41", 0, 1, 3'b001, 32'h41, 32'hFFFFFFFF, 32'h0, 1);
    req("t4_w011", 1, 0, 3'b011, 32'h40, 32'h0, 32'h0, 1);
    req("t4_both", 1, 1, 3'b010, 32'h40, 32'hFFFFFFFF, 32'h0, 1);
    req("t4_none", 0, 0, 3'b010, 32'h40, 32'hFFFFFFFF, 32'h0, 1);
    req("t4_sbu", 0, 1, 3'b100, 32'h40, 32'hFFFFFFFF, 32'h0, 1);
    req("t4_lw40", 1, 0, 3'b010, 32'h40, 32'h0, 32'h5566AA44, 0);
    drain("t4");

    // Test 6: address beyond the array
    req("t6_sw00", 0, 1, 3'b010, 32'h00, 32'h13579BDF, 32'h0, 0);
`ifdef BYTE_DATA_MEMORY_BOUNDS_CHECK_EN
    req("t6_lw400", 1, 0, 3'b010, 32'h400, 32'h0, 32'h0, 1);
    req("t6_sw400", 0, 1, 3'b010, 32'h400, 32'h2468ACE0, 32'h0, 1);
    req("t6_lw00", 1, 0, 3'b010, 32'h00, 32'h0, 32'h13579BDF, 0);
`else
    req("t6_lw400", 1, 0, 3'b010, 32'h400, 32'h0, 32'h13579BDF, 0);
    req("t6_sw400", 0, 1, 3'b010, 32'h400, 32'h2468ACE0, 32'h0, 0);
    req("t6_lw00", 1, 0, 3'b010, 32'h00, 32'h0, 32'h2468ACE0, 0);
`endif

    // Test 5: eight back-to-back requests including read-after-write
    req("t5_sw60", 0, 1, 3'b010, 32'h60, 32'h01020304, 32'h0, 0);
    req("t5_lw60", 1, 0, 3'b010, 32'h60, 32'h0, 32'h01020304, 0);
    req("t5_sw64", 0, 1, 3'b010, 32'h64, 32'hA0B0C0D0, 32'h0, 0);
    req("t5_lb64", 1, 0, 3'b000, 32'h64, 32'h0, 32'hFFFFFFD0, 0);
    req("t5_lhu66", 1, 0, 3'b101, 32'h66, 32'h0, 32'h0000A0B0, 0);
    req("t5_lh62", 1, 0, 3'b001, 32'h62, 32'h0, 32'h00000102, 0);
    req("t5_lbu61", 1, 0, 3'b100, 32'h61, 32'h0, 32'h00000003, 0);
    req("t5_lw64", 1, 0, 3'b010, 32'h64, 32'h0, 32'hA0B0C0D0, 0);
    drain("t5");

    // Test 5b: async reset while a response is in flight
    req("t5b_a", 1, 0, 3'b010, 32'h60, 32'h0, 32'h01020304, 0);
    req("t5b_b", 1, 0, 3'b010, 32'h64, 32'h0, 32'hA0B0C0D0, 0);
    req("t5b_c", 1, 0, 3'b010, 32'h40, 32'h0, 32'h5566AA44, 0);
    #1;
    reset = 1'b1;
    #1;
    check("t5b_resp_dropped", {31'd0, resp_valid}, 32'd0);
    check("t5b_ready_dropped", {31'd0, req_ready}, 32'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    wait_ready(n);
    check("t5b_sweep_len", n, DEPTH);
    req("t5b_lw60", 1, 0, 3'b010, 32'h60, 32'h0, 32'h0, 0);
    req("t5b_lw40", 1, 0, 3'b010, 32'h40, 32'h0, 32'h0, 0);
    drain("end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
